seq_alu_param: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit single-cycle ALU. Keeps the eight legacy op codes and adds:
- WIDTH generalisation
- multi-cycle variable-amount shifts
- iterative shift-add multiply
- arithmetic shift right
- status flags and valid/ready flow control
It sits between the operand register file and the writeback stage of the lab datapath.

---
 rtl/seq_alu_param.sv | 218 +++++++++++++++++++++
 tb/tb_seq_alu_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_param.sv
// Handshaked, parametrised ALU: single-cycle logic/arith ops, bit-serial shifts
// and a radix-2 shift-add multiplier behind an IDLE/EXEC/DONE controller.
module seq_alu_param #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output logic             err
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_PASS = 4'b0010;
  localparam logic [3:0] OP_SHL = 4'b0011;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ASR = 4'b1001;
  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t               state_r, state_s;
  logic                 in_ready_r, out_valid_r, in_ready_s, out_valid_s;
  logic [WIDTH-1:0]     a_r, sh_r, result_r, result_hi_r;
  logic [3:0]           func_r;
  logic [2*WIDTH-1:0]   prod_r, prod_next_s;
  logic [SHW:0]         cnt_r;
  logic                 carry_r, zero_r, negative_r, overflow_r, err_r;
  logic [WIDTH:0]       sum_s, diff_s, mul_sum_s;
  logic [WIDTH-1:0]     single_res_s, sh_next_s;
  logic                 single_carry_s, single_ovf_s, single_err_s, sh_out_s;
  logic                 accept_s, is_shift_s, multi_s, last_step_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign carry_out = carry_r;
  assign zero      = zero_r;
  assign negative  = negative_r;
  assign overflow  = overflow_r;
  assign err       = err_r;

  assign accept_s    = in_valid && in_ready_r;
  assign is_shift_s  = (func == OP_SHL) || (func == OP_SHR) || (func == OP_ASR);
  assign multi_s     = (func == OP_MUL) || (is_shift_s && (b[SHW-1:0] != {SHW{1'b0}}));
  assign last_step_s = (cnt_r == {{SHW{1'b0}}, 1'b1});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = multi_s ? EXEC : DONE;
        else          state_s = IDLE;
      end
      EXEC: begin
        if (last_step_s) state_s = DONE;
        else             state_s = EXEC;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the upcoming state
  always_comb begin
    in_ready_s  = (state_s == IDLE);
    out_valid_s = (state_s == DONE);
  end

  // Registered handshake outputs; in_ready stays low during reset itself
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Single-cycle results from the live operands (used on the accept edge)
  always_comb begin
    sum_s          = {1'b0, a} + {1'b0, b};
    diff_s         = {1'b0, a} - {1'b0, b};
    single_res_s   = {WIDTH{1'b0}};
    single_carry_s = 1'b0;
    single_ovf_s   = 1'b0;
    single_err_s   = 1'b0;
    case (func)
      OP_ADD: begin
        single_res_s   = sum_s[WIDTH-1:0];
        single_carry_s = sum_s[WIDTH];
        single_ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        single_res_s   = diff_s[WIDTH-1:0];
        single_carry_s = diff_s[WIDTH];
        single_ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_PASS, OP_SHL, OP_SHR, OP_ASR: single_res_s = a;
      OP_AND:  single_res_s = a & b;
      OP_NOT:  single_res_s = ~a;
      OP_OR:   single_res_s = a | b;
      OP_MUL:  single_res_s = {WIDTH{1'b0}};
      default: single_err_s = 1'b1;
    endcase
  end

  // One iteration of the shifter and of the shift-add multiplier
  always_comb begin
    sh_next_s = sh_r;
    sh_out_s  = 1'b0;
    case (func_r)
      OP_SHL: begin
        sh_next_s = {sh_r[WIDTH-2:0], 1'b0};
        sh_out_s  = sh_r[WIDTH-1];
      end
      OP_SHR: begin
        sh_next_s = {1'b0, sh_r[WIDTH-1:1]};
        sh_out_s  = sh_r[0];
      end
      OP_ASR: begin
        sh_next_s = {sh_r[WIDTH-1], sh_r[WIDTH-1:1]};
        sh_out_s  = sh_r[0];
      end
      default: begin
        sh_next_s = sh_r;
        sh_out_s  = 1'b0;
      end
    endcase
    mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                  (prod_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    prod_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

  // Operand capture, iteration state and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= {WIDTH{1'b0}};
      sh_r        <= {WIDTH{1'b0}};
      prod_r      <= {(2*WIDTH){1'b0}};
      func_r      <= 4'b0000;
      cnt_r       <= {(SHW+1){1'b0}};
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      zero_r      <= 1'b0;
      negative_r  <= 1'b0;
      overflow_r  <= 1'b0;
      err_r       <= 1'b0;
    end else if (state_r == IDLE && accept_s) begin
      a_r    <= a;
      sh_r   <= a;
      prod_r <= {{WIDTH{1'b0}}, b};
      func_r <= func;
      cnt_r  <= (func == OP_MUL) ? MUL_CNT : {1'b0, b[SHW-1:0]};
      if (!multi_s) begin
        result_r    <= single_res_s;
        result_hi_r <= {WIDTH{1'b0}};
        carry_r     <= single_carry_s;
        overflow_r  <= single_ovf_s;
        err_r       <= single_err_s;
        zero_r      <= !single_err_s && (single_res_s == {WIDTH{1'b0}});
        negative_r  <= single_res_s[WIDTH-1];
      end
    end else if (state_r == EXEC) begin
      cnt_r  <= cnt_r - {{SHW{1'b0}}, 1'b1};
      sh_r   <= sh_next_s;
      prod_r <= prod_next_s;
      if (last_step_s) begin
        overflow_r <= 1'b0;
        err_r      <= 1'b0;
        if (func_r == OP_MUL) begin
          result_r    <= prod_next_s[WIDTH-1:0];
          result_hi_r <= prod_next_s[2*WIDTH-1:WIDTH];
          carry_r     <= 1'b0;
          zero_r      <= (prod_next_s == {(2*WIDTH){1'b0}});
          negative_r  <= prod_next_s[2*WIDTH-1];
        end else begin
          result_r    <= sh_next_s;
          result_hi_r <= {WIDTH{1'b0}};
          carry_r     <= sh_out_s;
          zero_r      <= (sh_next_s == {WIDTH{1'b0}});
          negative_r  <= sh_next_s[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_param.sv
// Randomised and directed bench for seq_alu_param (WIDTH=8) checked against an
// arithmetic reference model of the op table.
module tb_seq_alu_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [3:0] func = 4'h0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result, result_hi;
  logic       carry_out, zero, negative, overflow, err;

  int checks = 0;
  int failures = 0;

  seq_alu_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .func(func), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .carry_out(carry_out),
    .zero(zero), .negative(negative), .overflow(overflow), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] observed();
    return {result, result_hi, carry_out, zero, negative, overflow, err};
  endfunction

  // Reference: {res, hi, carry, zero, negative, overflow, err} plus latency
  function automatic void model(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv,
                                output logic [20:0] exp_v, output int lat);
    int ua, ub, amt, p, sa;
    logic [7:0] res, hi;
    logic c, o, e, z, n;
    ua = int'(av); ub = int'(bv); amt = ub % 8; sa = int'($signed(av));
    p = 0; res = 8'h00; hi = 8'h00; c = 1'b0; o = 1'b0; e = 1'b0; lat = 1;
    case (f)
      4'd0: begin p = ua + ub; res = 8'(p); c = (p > 255);
                  o = (av[7] == bv[7]) && (res[7] != av[7]); end
      4'd1: begin res = 8'(ua - ub); c = (ua < ub);
                  o = (av[7] != bv[7]) && (res[7] != av[7]); end
      4'd2: res = av;
      4'd3: begin res = 8'(ua << amt); c = (amt != 0) && (((ua >> (8 - amt)) & 1) != 0); lat = amt + 1; end
      4'd4: begin res = 8'(ua >> amt); c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); lat = amt + 1; end
      4'd5: res = av & bv;
      4'd6: res = ~av;
      4'd7: res = av | bv;
      4'd8: begin p = ua * ub; res = 8'(p); hi = 8'(p >> 8); lat = 9; end
      4'd9: begin res = 8'(sa >>> amt); c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); lat = amt + 1; end
      default: e = 1'b1;
    endcase
    if (e) begin z = 1'b0; n = 1'b0; end
    else if (f == 4'd8) begin z = (p == 0); n = hi[7]; end
    else begin z = (res == 8'h00); n = res[7]; end
    exp_v = {res, hi, c, z, n, o, e};
  endfunction

  // Present one operation, then scramble inputs and count edges to out_valid
  task automatic run_op(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv, output int lat);
    int w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    func = f; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); func = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({observed(), out_valid} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {observed(), out_valid});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  d_f[12]   = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h9, 4'h4, 4'h3, 4'h8, 4'h8, 4'hA};
    logic [7:0]  d_a[12]   = '{8'h01, 8'hFF, 8'h7F, 8'h01, 8'h04, 8'h81, 8'h80, 8'h41, 8'h5A, 8'hFF, 8'h00, 8'h12};
    logic [7:0]  d_b[12]   = '{8'h03, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'h37, 8'h34};
    logic [20:0] d_exp[12] = '{{8'h04, 8'h00, 5'b00000}, {8'h00, 8'h00, 5'b11000},
                               {8'h80, 8'h00, 5'b00110}, {8'hFF, 8'h00, 5'b10100},
                               {8'h03, 8'h00, 5'b00000}, {8'h08, 8'h00, 5'b00000},
                               {8'hE0, 8'h00, 5'b00100}, {8'h20, 8'h00, 5'b10000},
                               {8'h5A, 8'h00, 5'b00000}, {8'h01, 8'hFE, 5'b00100},
                               {8'h00, 8'h00, 5'b01000}, {8'h00, 8'h00, 5'b00001}};
    int d_lat[12] = '{1, 1, 1, 1, 1, 4, 3, 2, 1, 9, 9, 1};
    int lat;
    for (int i = 0; i < 12; i++) begin
      run_op(d_f[i], d_a[i], d_b[i], lat);
      checks++;
      if (observed() !== d_exp[i] || lat != d_lat[i]) begin
        failures++;
        $display("FAIL directed_%0d got=%h lat=%0d want=%h lat=%0d", i, observed(), lat, d_exp[i], d_lat[i]);
      end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    logic [3:0] f;
    logic [7:0] av, bv;
    int lat, exp_lat;
    for (int i = 0; i < 150; i++) begin
      f  = (i % 5 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      av = 8'($urandom); bv = 8'($urandom);
      model(f, av, bv, exp_v, exp_lat);
      run_op(f, av, bv, lat);
      checks++;
      if (observed() !== exp_v || lat != exp_lat) begin
        failures++;
        $display("FAIL random_%0d f=%h a=%h b=%h got=%h lat=%0d want=%h lat=%0d",
                 i, f, av, bv, observed(), lat, exp_v, exp_lat);
      end
      release_result();
    end
  endtask

  task automatic test_backpressure();
    logic [20:0] exp_v;
    int lat, exp_lat;
    model(4'h0, 8'h7F, 8'h01, exp_v, exp_lat);
    run_op(4'h0, 8'h7F, 8'h01, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; func = 4'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      checks++;
      if (observed() !== exp_v || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold_%0d got=%h rdy=%b vld=%b want=%h rdy=0 vld=1",
                 i, observed(), in_ready, out_valid, exp_v);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_not_queued vld=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[6] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7};
    logic [3:0] f;
    logic [7:0] av, bv;
    logic [20:0] exp_v;
    int exp_lat, w;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    out_ready = 1'b1;
    f = ops[$urandom_range(0, 5)]; av = 8'($urandom); bv = 8'($urandom);
    func = f; a = av; b = bv; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      model(f, av, bv, exp_v, exp_lat);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || observed() !== exp_v) begin
        failures++;
        $display("FAIL b2b_result_%0d vld=%b got=%h want vld=1 %h", k, out_valid, observed(), exp_v);
      end
      f = ops[$urandom_range(0, 5)]; av = 8'($urandom); bv = 8'($urandom);
      func = f; a = av; b = bv;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_idle_%0d vld=%b rdy=%b want vld=0 rdy=1", k, out_valid, in_ready);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int w = 0;
    bit saw_valid = 1'b0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    func = 4'h8; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mul_exec_busy vld=%b rdy=%b want vld=0 rdy=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({observed(), out_valid} !== 22'h0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h want=0", {observed(), out_valid});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_in_ready got=%b want=1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) saw_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (saw_valid || result !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_abandoned saw_valid=%b result=%h want 0 00", saw_valid, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
